// File: rtl/ren_conv_seq_if.sv
// ren_conv_seq_if: bundles the job descriptor port, the result stream port and
// the Wishbone master bus of the ren_conv_seq job sequencer.
//   job_*   : descriptor in (valid/ready), plus job_done / job_err pulses out
//   rslt_*  : result word stream out (valid/ready, last marker)
//   wbm_*   : classic single-access Wishbone master towards the engine
// The master modport is the sequencer's view; slave is the environment's view.
interface ren_conv_seq_if #(
  parameter int RSLT_ADDR_WIDTH = 6
);
  logic                     job_valid;
  logic                     job_ready;
  logic [31:0]              job_cfg1;
  logic [31:0]              job_cfg2;
  logic [RSLT_ADDR_WIDTH:0] job_nres;
  logic                     job_done;
  logic                     job_err;

  logic                     rslt_valid;
  logic                     rslt_ready;
  logic [31:0]              rslt_data;
  logic                     rslt_last;

  logic                     wbm_cyc_o;
  logic                     wbm_stb_o;
  logic                     wbm_we_o;
  logic [3:0]               wbm_sel_o;
  logic [31:0]              wbm_adr_o;
  logic [31:0]              wbm_dat_o;
  logic                     wbm_ack_i;
  logic [31:0]              wbm_dat_i;

  modport master (
    input  job_valid, job_cfg1, job_cfg2, job_nres, rslt_ready, wbm_ack_i, wbm_dat_i,
    output job_ready, job_done, job_err, rslt_valid, rslt_data, rslt_last,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output job_valid, job_cfg1, job_cfg2, job_nres, rslt_ready, wbm_ack_i, wbm_dat_i,
    input  job_ready, job_done, job_err, rslt_valid, rslt_data, rslt_last,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/ren_conv_seq.sv
// ren_conv_seq: Wishbone-master job sequencer for one ren_conv_top engine.
// Accepts a descriptor (cfg1, cfg2, result count), writes engine reg1/reg2,
// issues the start command, polls reg0 until the done bit is set (with a poll
// limit that raises job_err), then reads the result memory one word at a time
// and streams each word out, waiting for the consumer before the next read.
// Ports:
//   wb_clk_i  : clock
//   wb_rst_ni : asynchronous active-low reset
//   bus       : ren_conv_seq_if.master (descriptor, result stream, Wishbone)
// All outputs are driven straight from flops.
module ren_conv_seq #(
  parameter logic [31:0] REG_BASE_ADDR   = 32'h000,
  parameter logic [31:0] RES_BASE_ADDR   = 32'h300,
  parameter int          RSLT_ADDR_WIDTH = 6,
  parameter int          DONE_BIT        = 0,
  parameter int          POLL_GAP        = 4,
  parameter int          POLL_MAX        = 255
) (
  input logic            wb_clk_i,
  input logic            wb_rst_ni,
  ren_conv_seq_if.master bus
);

  localparam int IW = RSLT_ADDR_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE, WR_CFG1, WR_CFG2, WR_START, POLL_WAIT, POLL_RD, RES_RD, RES_OUT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic [IW-1:0] nres_q, nres_d, idx_q, idx_d;
  logic [15:0]   poll_q, poll_d, gap_q, gap_d, poll_inc;
  logic          cyc_q, cyc_d, we_q, we_d;
  logic [31:0]   adr_q, adr_d, dat_q, dat_d;
  logic          ready_q, ready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          done_q, done_d, err_q, err_d;

  // Access described by the current bus state
  logic          bus_state, acc_we, acc_done;
  logic [31:0]   acc_adr, acc_dat;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  always_comb begin
    bus_state = 1'b1;
    acc_we    = 1'b0;
    acc_adr   = '0;
    acc_dat   = '0;
    case (state_q)
      WR_CFG1:  begin acc_we = 1'b1; acc_adr = REG_BASE_ADDR + 32'd1; acc_dat = cfg1_q; end
      WR_CFG2:  begin acc_we = 1'b1; acc_adr = REG_BASE_ADDR + 32'd2; acc_dat = cfg2_q; end
      WR_START: begin acc_we = 1'b1; acc_adr = REG_BASE_ADDR;         acc_dat = 32'h4;  end
      POLL_RD:  acc_adr = REG_BASE_ADDR;
      RES_RD:   acc_adr = RES_BASE_ADDR + 32'(idx_q);
      default:  bus_state = 1'b0;
    endcase
  end

  assign acc_done = cyc_q & bus.wbm_ack_i;
  assign poll_inc = sat_inc16(poll_q);

  always_comb begin
    state_d  = state_q;
    cfg1_d   = cfg1_q;
    cfg2_d   = cfg2_q;
    nres_d   = nres_q;
    idx_d    = idx_q;
    poll_d   = poll_q;
    gap_d    = gap_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    ready_d  = ready_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    // Every bus state opens its access one cycle after entry; the cycle that
    // closes on ack is also the state change, so consecutive accesses are
    // always separated by at least one idle cycle.
    if (bus_state) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        we_d  = acc_we;
        adr_d = acc_adr;
        dat_d = acc_dat;
      end else if (bus.wbm_ack_i) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        // After a job_err pulse the FSM sits here one cycle with ready low
        if (!ready_q) begin
          ready_d = 1'b1;
        end else if (bus.job_valid) begin
          cfg1_d  = bus.job_cfg1;
          cfg2_d  = bus.job_cfg2;
          nres_d  = bus.job_nres;
          poll_d  = '0;
          ready_d = 1'b0;
          state_d = WR_CFG1;
        end
      end
      WR_CFG1:  if (acc_done) state_d = WR_CFG2;
      WR_CFG2:  if (acc_done) state_d = WR_START;
      WR_START: if (acc_done) begin state_d = POLL_WAIT; gap_d = '0; end
      POLL_WAIT: begin
        gap_d = gap_q + 16'd1;
        if ((32'(gap_q) + 32'd1) >= 32'(POLL_GAP)) begin
          gap_d   = '0;
          state_d = POLL_RD;
        end
      end
      POLL_RD: begin
        if (acc_done) begin
          poll_d = poll_inc;
          if (bus.wbm_dat_i[DONE_BIT]) begin
            idx_d = '0;
            if (nres_q == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RES_RD;
            end
          end else if (32'(poll_inc) == 32'(POLL_MAX)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            gap_d   = '0;
            state_d = POLL_WAIT;
          end
        end
      end
      RES_RD: begin
        if (acc_done) begin
          rdata_d  = bus.wbm_dat_i;
          rvalid_d = 1'b1;
          rlast_d  = (idx_q == nres_q - IW'(1));
          state_d  = RES_OUT;
        end
      end
      RES_OUT: begin
        if (bus.rslt_ready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          idx_d    = idx_q + IW'(1);
          if (idx_q + IW'(1) == nres_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RES_RD;
          end
        end
      end
      DONE: begin
        // job_done is high for exactly this cycle; ready returns with its fall
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= IDLE;
      cfg1_q   <= '0;
      cfg2_q   <= '0;
      nres_q   <= '0;
      idx_q    <= '0;
      poll_q   <= '0;
      gap_q    <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg1_q   <= cfg1_d;
      cfg2_q   <= cfg2_d;
      nres_q   <= nres_d;
      idx_q    <= idx_d;
      poll_q   <= poll_d;
      gap_q    <= gap_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.job_ready  = ready_q;
  assign bus.job_done   = done_q;
  assign bus.job_err    = err_q;
  assign bus.rslt_valid = rvalid_q;
  assign bus.rslt_data  = rdata_q;
  assign bus.rslt_last  = rlast_q;
  assign bus.wbm_cyc_o  = cyc_q;
  assign bus.wbm_stb_o  = cyc_q;
  assign bus.wbm_we_o   = we_q;
  assign bus.wbm_sel_o  = {4{cyc_q}};
  assign bus.wbm_adr_o  = adr_q;
  assign bus.wbm_dat_o  = dat_q;

endmodule

// File: tb/tb_ren_conv_seq.sv
// tb_ren_conv_seq: self-checking bench for ren_conv_seq.
// A behavioural Wishbone slave models the engine (status reg0 with a done
// bit after a programmable number of polls, result memory at 0x300). Each job
// pushes its expected bus accesses and result words to queues; monitors pop
// and compare them as the sequencer produces them.
`timescale 1ns/1ps
module tb_ren_conv_seq;

  localparam int RAW  = 6;
  localparam int PMAX = 3;

  logic clk;
  logic rst_n;

  ren_conv_seq_if #(.RSLT_ADDR_WIDTH(RAW)) bus ();

  ren_conv_seq #(.RSLT_ADDR_WIDTH(RAW), .POLL_MAX(PMAX)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } res_t;

  acc_t exp_acc[$];
  res_t exp_res[$];

  int checks = 0;
  int failures = 0;

  // slave model state
  int          done_after = 1000;
  int          max_wait = 0;
  int          st_polls = 0;
  int          wait_left = -1;
  logic        stall = 1'b0;
  logic [31:0] salt = 32'h0;

  // monitor / driver shared state
  int done_cnt = 0;
  int err_cnt = 0;
  int res_seen = 0;
  int bp_left = 0;
  int bp_word = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res_word(input int i, input logic [31:0] s);
    return 32'hC0DE0000 ^ s ^ (32'(i) * 32'h01000101);
  endfunction

  function automatic void push_acc(input logic w, input logic [31:0] a, input logic [31:0] d);
    acc_t x;
    x.we  = w;
    x.adr = a;
    x.dat = d;
    exp_acc.push_back(x);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine slave: ack after 0..max_wait wait cycles, one-cycle ack pulse
  initial begin
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.wbm_ack_i = 1'b0;
        wait_left = -1;
      end else if (bus.wbm_ack_i) begin
        bus.wbm_ack_i = 1'b0;
      end else if (bus.wbm_cyc_o && bus.wbm_stb_o && !stall) begin
        if (wait_left < 0) wait_left = (max_wait > 0) ? int'($urandom_range(max_wait)) : 0;
        if (wait_left == 0) begin
          wait_left = -1;
          bus.wbm_ack_i = 1'b1;
          if (bus.wbm_we_o) begin
            if (bus.wbm_adr_o == 32'h0 && bus.wbm_dat_o[2]) st_polls = 0;
            bus.wbm_dat_i = 32'hDEAD_BEEF;
          end else if (bus.wbm_adr_o == 32'h0) begin
            st_polls++;
            bus.wbm_dat_i = 32'h5A5A_5A5A | {31'd0, (st_polls >= done_after)};
          end else begin
            bus.wbm_dat_i = res_word(int'(bus.wbm_adr_o - 32'h300), salt);
          end
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Result consumer: ready except for bp_left cycles once word bp_word is shown
  initial begin
    bus.rslt_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bp_left > 0 && bus.rslt_valid && res_seen == bp_word) begin
        bus.rslt_ready = 1'b0;
        bp_left--;
      end else begin
        bus.rslt_ready = 1'b1;
      end
    end
  end

  // Monitor: bus accesses, result stream and completion pulses
  initial begin
    logic        prev_open;
    logic        prev_closed;
    logic [31:0] prev_adr;
    logic [31:0] prev_dat;
    logic        prev_we;
    logic        prev_rwait;
    logic [31:0] prev_rdata;
    logic        prev_rlast;
    logic        prev_pulse;
    acc_t        a;
    res_t        r;
    prev_open = 1'b0; prev_closed = 1'b0; prev_rwait = 1'b0; prev_pulse = 1'b0;
    prev_adr = '0; prev_dat = '0; prev_we = 1'b0; prev_rdata = '0; prev_rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_open = 1'b0; prev_closed = 1'b0; prev_rwait = 1'b0; prev_pulse = 1'b0;
        continue;
      end
      if (prev_closed) chk("idle_gap", 32'(bus.wbm_cyc_o), 32'd0);
      if (bus.wbm_cyc_o && prev_open) begin
        chk("adr_stable", bus.wbm_adr_o, prev_adr);
        chk("we_stable", 32'(bus.wbm_we_o), 32'(prev_we));
        if (bus.wbm_we_o) chk("dat_stable", bus.wbm_dat_o, prev_dat);
      end
      prev_closed = 1'b0;
      if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i) begin
        prev_closed = 1'b1;
        chk("sel", 32'(bus.wbm_sel_o), 32'hf);
        chk("acc_expected", 32'(exp_acc.size() != 0), 32'd1);
        if (bus.wbm_adr_o >= 32'h300) chk("no_readahead", 32'(bus.rslt_valid), 32'd0);
        if (exp_acc.size() != 0) begin
          a = exp_acc.pop_front();
          chk("acc_we", 32'(bus.wbm_we_o), 32'(a.we));
          chk("acc_adr", bus.wbm_adr_o, a.adr);
          if (a.we) chk("acc_dat", bus.wbm_dat_o, a.dat);
        end
      end
      prev_open = bus.wbm_cyc_o & ~bus.wbm_ack_i;
      prev_adr  = bus.wbm_adr_o;
      prev_dat  = bus.wbm_dat_o;
      prev_we   = bus.wbm_we_o;

      if (bus.rslt_valid && prev_rwait) begin
        chk("rdata_stable", bus.rslt_data, prev_rdata);
        chk("rlast_stable", 32'(bus.rslt_last), 32'(prev_rlast));
      end
      if (bus.rslt_valid && bus.rslt_ready) begin
        chk("res_expected", 32'(exp_res.size() != 0), 32'd1);
        if (exp_res.size() != 0) begin
          r = exp_res.pop_front();
          chk("rslt_data", bus.rslt_data, r.d);
          chk("rslt_last", 32'(bus.rslt_last), 32'(r.last));
        end
        res_seen++;
      end
      prev_rwait = bus.rslt_valid & ~bus.rslt_ready;
      prev_rdata = bus.rslt_data;
      prev_rlast = bus.rslt_last;

      if (prev_pulse) begin
        chk("pulse_width", 32'(bus.job_done | bus.job_err), 32'd0);
        chk("ready_after_pulse", 32'(bus.job_ready), 32'd1);
      end
      if (bus.job_done || bus.job_err) chk("ready_in_pulse", 32'(bus.job_ready), 32'd0);
      if (bus.job_done) done_cnt++;
      if (bus.job_err) err_cnt++;
      prev_pulse = bus.job_done | bus.job_err;
    end
  end

  // Present one descriptor and wait for its acceptance
  task automatic give_job(input logic [31:0] c1, input logic [31:0] c2, input int nres);
    int n;
    @(negedge clk);
    bus.job_cfg1  = c1;
    bus.job_cfg2  = c2;
    bus.job_nres  = 7'(nres);
    bus.job_valid = 1'b1;
    n = 0;
    while (!bus.job_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_idle", 32'(bus.job_ready), 32'd1);
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
    chk("ready_drop", 32'(bus.job_ready), 32'd0);
  endtask

  task automatic run_job(input logic [31:0] c1, input logic [31:0] c2, input int nres,
                         input int polls, input int maxw, input bit exp_err);
    int   d0, e0, n;
    res_t r;
    salt       = $urandom;
    done_after = polls;
    max_wait   = maxw;
    push_acc(1'b1, 32'h001, c1);
    push_acc(1'b1, 32'h002, c2);
    push_acc(1'b1, 32'h000, 32'h4);
    n = exp_err ? PMAX : polls;
    for (int i = 0; i < n; i++) push_acc(1'b0, 32'h000, 32'h0);
    if (!exp_err) begin
      for (int i = 0; i < nres; i++) begin
        push_acc(1'b0, 32'h300 + 32'(i), 32'h0);
        r.d    = res_word(i, salt);
        r.last = (i == nres - 1);
        exp_res.push_back(r);
      end
    end
    d0 = done_cnt;
    e0 = err_cnt;
    give_job(c1, c2, nres);
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 20000) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("done_count", 32'(done_cnt - d0), exp_err ? 32'd0 : 32'd1);
    chk("err_count", 32'(err_cnt - e0), exp_err ? 32'd1 : 32'd0);
    chk("acc_left", 32'(exp_acc.size()), 32'd0);
    chk("res_left", 32'(exp_res.size()), 32'd0);
    chk("ready_back", 32'(bus.job_ready), 32'd1);
    exp_acc.delete();
    exp_res.delete();
  endtask

  initial begin
    int d0, e0, n;
    rst_n         = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_cfg1  = '0;
    bus.job_cfg2  = '0;
    bus.job_nres  = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.job_ready), 32'd1);
    chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    chk("rst_we", 32'(bus.wbm_we_o), 32'd0);
    chk("rst_sel", 32'(bus.wbm_sel_o), 32'd0);
    chk("rst_adr", bus.wbm_adr_o, 32'd0);
    chk("rst_dat", bus.wbm_dat_o, 32'd0);
    chk("rst_rvalid", 32'(bus.rslt_valid), 32'd0);
    chk("rst_rdata", bus.rslt_data, 32'd0);
    chk("rst_rlast", 32'(bus.rslt_last), 32'd0);
    chk("rst_done", 32'(bus.job_done), 32'd0);
    chk("rst_err", 32'(bus.job_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(bus.job_ready), 32'd1);

    // basic job
    run_job(32'h01020702, 32'h001E0C0B, 4, 3, 0, 1'b0);

    // backpressure on word 2
    bp_word = res_seen + 1;
    bp_left = 5;
    run_job(32'h01020702, 32'h001E0C0B, 4, 2, 0, 1'b0);
    chk("bp_applied", 32'(bp_left), 32'd0);

    // poll timeout
    run_job(32'h11111111, 32'h22222222, 4, 1000, 0, 1'b1);

    // zero results
    run_job(32'h0A0B0C0D, 32'h00030201, 0, 2, 0, 1'b0);

    // wait-state slave
    run_job(32'h33445566, 32'h000F00FF, 5, 2, 4, 1'b0);
    run_job(32'h77665544, 32'h00000001, 1, 1, 4, 1'b0);

    // full result memory
    run_job(32'h0000FF01, 32'h00000040, 64, 1, 0, 1'b0);

    // reset during a poll read that the slave never acknowledges
    stall      = 1'b1;
    done_after = 1000;
    max_wait   = 0;
    push_acc(1'b1, 32'h001, 32'hABCD0001);
    push_acc(1'b1, 32'h002, 32'hABCD0002);
    push_acc(1'b1, 32'h000, 32'h4);
    d0 = done_cnt;
    e0 = err_cnt;
    // writes must complete, so stall only after the start write
    stall = 1'b0;
    give_job(32'hABCD0001, 32'hABCD0002, 3);
    n = 0;
    while (exp_acc.size() != 0 && n < 200) begin @(negedge clk); n++; end
    stall = 1'b1;
    n = 0;
    while (!(bus.wbm_cyc_o && !bus.wbm_we_o && bus.wbm_adr_o == 32'h0) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("poll_seen", 32'(bus.wbm_cyc_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    chk("rst_async_stb", 32'(bus.wbm_stb_o), 32'd0);
    chk("rst_async_ready", 32'(bus.job_ready), 32'd1);
    repeat (2) @(negedge clk);
    stall = 1'b0;
    exp_acc.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_no_err", 32'(err_cnt - e0), 32'd0);
    chk("rst_idle_ready", 32'(bus.job_ready), 32'd1);
    run_job(32'h5555AAAA, 32'h00000102, 3, 2, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
